// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared types and constants for the programming-memory
//                timing controller (state encoding, bus widths, default
//                access timing, timer range helper).
//  Revision    : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    // Default access timing in clk cycles
    localparam int WR_CYCLES_DEF  = 24;
    localparam int RD_CYCLES_DEF  = 14;
    localparam int GAP_CYCLES_DEF = 2;
    localparam int CNT_W_DEF      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        GAP    = 2'd2
    } state_t;

    // A cycle count is usable when non-zero and representable by the timer
    function automatic bit cycles_in_range(input int cycles, input int cnt_w);
        return (cycles >= 1) && (cycles <= (2 ** cnt_w) - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_timer
//  Description : Up-counting cycle timer. i_clr restarts the count at zero,
//                i_load captures the terminal count, o_done flags the cycle
//                in which the count equals the terminal count.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_last,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last;

    // Count register and terminal-count register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_last <= '0;
        end else begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (i_load) begin
                r_last <= i_last;
            end
        end
    end

    assign o_done = (r_cnt == r_last);

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Timing master for the 256x16 programming memory. Accepts one
//                read/write request at a time, holds the memory strobes for
//                the access window, returns read data, then enforces a
//                deselect gap before the next access.
//                Optional feature macro: MEM_CTRL_AUTOINC_EN (adds req_inc
//                and an internal address pointer for sequential accesses).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WR_CYCLES  = WR_CYCLES_DEF,
    parameter int RD_CYCLES  = RD_CYCLES_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_CTRL_AUTOINC_EN
    input  logic              req_inc,
`endif
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Reject timings the timer cannot represent
    if (!cycles_in_range(WR_CYCLES, CNT_W)) begin : g_bad_wr_cycles
        $error("mem_ctrl: WR_CYCLES out of range for CNT_W");
    end
    if (!cycles_in_range(RD_CYCLES, CNT_W)) begin : g_bad_rd_cycles
        $error("mem_ctrl: RD_CYCLES out of range for CNT_W");
    end
    if (!cycles_in_range(GAP_CYCLES, CNT_W)) begin : g_bad_gap_cycles
        $error("mem_ctrl: GAP_CYCLES out of range for CNT_W");
    end

    // Timer terminal counts: the timer starts at 0 on state entry
    localparam logic [CNT_W-1:0] c_WR_LAST  = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_RD_LAST  = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_tmr_done;
    logic               w_tmr_clr;
    logic [CNT_W-1:0]   w_tmr_last;
    logic [ADDR_W-1:0]  w_req_addr;

    logic               w_ready_nxt;
    logic               w_busy_nxt;
    logic               w_rsp_valid_nxt;
    logic [DATA_W-1:0]  w_rdata_nxt;
    logic               w_sel_nxt;
    logic               w_we_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [DATA_W-1:0]  w_wdata_nxt;

    assign w_accept = req_valid & req_ready;

`ifdef MEM_CTRL_AUTOINC_EN
    logic [ADDR_W-1:0] r_ptr;

    assign w_req_addr = req_inc ? (r_ptr + ADDR_W'(1)) : req_addr;

    // Pointer follows the address of every accepted request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_req_addr;
        end
    end
`else
    assign w_req_addr = req_addr;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE -> ACCESS -> GAP -> IDLE, phases timed by the timer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = ACCESS;
            ACCESS:  if (w_tmr_done) w_state_nxt = GAP;
            GAP:     if (w_tmr_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Timer restarts on every state change with the new phase length
    always_comb begin
        w_tmr_last = '0;
        case (w_state_nxt)
            ACCESS:  w_tmr_last = req_we ? c_WR_LAST : c_RD_LAST;
            GAP:     w_tmr_last = c_GAP_LAST;
            default: w_tmr_last = '0;
        endcase
    end

    assign w_tmr_clr = (w_state_nxt != r_state);

    mem_ctrl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_tmr_clr),
        .i_load (w_tmr_clr),
        .i_en   (r_state != IDLE),
        .i_last (w_tmr_last),
        .o_done (w_tmr_done)
    );

    // Output next-values; memory strobes only move at access start and end
    always_comb begin
        w_ready_nxt     = (w_state_nxt == IDLE);
        w_busy_nxt      = (w_state_nxt != IDLE);
        w_rsp_valid_nxt = 1'b0;
        w_rdata_nxt     = rsp_rdata;
        w_sel_nxt       = mem_sel;
        w_we_nxt        = mem_we;
        w_addr_nxt      = mem_addr;
        w_wdata_nxt     = mem_wdata;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_sel_nxt   = 1'b1;
                    w_we_nxt    = req_we;
                    w_addr_nxt  = w_req_addr;
                    w_wdata_nxt = req_wdata;
                end
            end
            ACCESS: begin
                if (w_tmr_done) begin
                    w_sel_nxt = 1'b0;
                    w_we_nxt  = 1'b0;
                    if (!mem_we) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rdata_nxt     = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_sel   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            req_ready <= w_ready_nxt;
            busy      <= w_busy_nxt;
            rsp_valid <= w_rsp_valid_nxt;
            rsp_rdata <= w_rdata_nxt;
            mem_sel   <= w_sel_nxt;
            mem_we    <= w_we_nxt;
            mem_addr  <= w_addr_nxt;
            mem_wdata <= w_wdata_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Scoreboard bench for mem_ctrl with a behavioural memory and
//                a reference model of expected accesses and responses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

    localparam int WR = 24;
    localparam int RD = 14;
    localparam int GP = 2;
`ifdef MEM_CTRL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
`ifdef MEM_CTRL_AUTOINC_EN
    logic        req_inc = 1'b0;
`endif
    logic        req_ready, rsp_valid, busy, mem_sel, mem_we;
    logic [15:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    always #1 clk = ~clk;

    mem_ctrl #(
        .WR_CYCLES  (WR),
        .RD_CYCLES  (RD),
        .GAP_CYCLES (GP),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef MEM_CTRL_AUTOINC_EN
        .req_inc   (req_inc),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .mem_sel   (mem_sel),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural 256x16 memory: data only driven inside a read window
    logic [15:0] mem_arr [256];
    always @(posedge clk) if (mem_sel && mem_we) mem_arr[mem_addr] <= mem_wdata;
    assign mem_rdata = (mem_sel && !mem_we) ? mem_arr[mem_addr] : 16'hxxxx;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model
    typedef struct { int start; int len; logic we; logic [7:0] addr; logic [15:0] wdata; } acc_t;
    typedef struct { int cyc; bit known; logic [15:0] data; } rsp_t;
    acc_t        exp_acc [$];
    rsp_t        exp_rsp [$];
    logic [15:0] ref_mem [256];
    bit          ref_def [256];
    logic [7:0]  ref_ptr = '0;

    // Present a request (called at a negedge), record expectations at acceptance
    task automatic issue(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                         input logic inc, input bit hold, output int acc);
        int n = 0;
        logic [7:0] ea;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
`ifdef MEM_CTRL_AUTOINC_EN
        req_inc = inc;
`endif
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        chk("req_accept", req_ready, 1);
        if (!req_ready) begin
            req_valid = 1'b0; acc = -1;
            return;
        end
        ea = (AUTOINC && inc) ? ref_ptr + 8'd1 : addr;
        ref_ptr = ea;
        acc = cyc + 1;
        exp_acc.push_back('{acc, we ? WR : RD, we, ea, wdata});
        if (we) begin
            ref_mem[ea] = wdata; ref_def[ea] = 1'b1;
        end else begin
            exp_rsp.push_back('{acc + RD, ref_def[ea], ref_mem[ea]});
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_acc.size() != 0 || exp_rsp.size() != 0 || busy) && n < 400) begin
            @(negedge clk); n++;
        end
        chk("drain_pending", exp_acc.size() + exp_rsp.size(), 0);
    endtask

    // Monitor / scoreboard
    acc_t        cur;
    rsp_t        r;
    int          sel_cnt = 0;
    int          gap_left = 0;
    bit          in_acc = 0, prev_sel = 0, prev_rsp = 0, exp_busy = 0;
    bit          last_known = 1;
    logic [15:0] last_rdata = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sel = 0; prev_rsp = 0; in_acc = 0; sel_cnt = 0; gap_left = 0;
            last_rdata = '0; last_known = 1;
        end else begin
            if (mem_sel && !prev_sel) begin
                if (exp_acc.size() == 0) begin
                    chk("unexpected_access", mem_sel, 0);
                end else begin
                    cur = exp_acc.pop_front(); in_acc = 1; sel_cnt = 0;
                    chk("acc_start", cyc, cur.start);
                end
            end
            if (mem_sel) begin
                sel_cnt++;
                if (in_acc) chk("acc_fields", {mem_we, mem_addr, mem_wdata}, {cur.we, cur.addr, cur.wdata});
            end else if (prev_sel) begin
                if (in_acc) chk("acc_len", sel_cnt, cur.len);
                in_acc = 0; gap_left = GP;
            end
            exp_busy = mem_sel || (gap_left > 0);
            chk("busy", busy, exp_busy);
            chk("req_ready", req_ready, !exp_busy);
            if (!mem_sel && gap_left > 0) begin
                chk("gap_hold", {mem_we, mem_addr, mem_wdata}, {1'b0, cur.addr, cur.wdata});
                gap_left--;
            end
            if (rsp_valid) begin
                chk("rsp_single", prev_rsp, 0);
                chk("rsp_known", $isunknown(rsp_rdata), 0);
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_cycle", cyc, r.cyc);
                    if (r.known) chk("rsp_data", rsp_rdata, r.data);
                    last_rdata = r.data; last_known = r.known;
                end
            end else if (last_known) begin
                chk("rsp_hold", rsp_rdata, last_rdata);
            end
            prev_sel = mem_sel; prev_rsp = rsp_valid;
        end
    end

    initial begin
        int a1, a2;
        logic [7:0] ra;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write then read back
        issue(1'b1, 8'h10, 16'hA5A5, 1'b0, 1'b0, a1);
        issue(1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, a1);
        drain();

        // Back-to-back with req_valid held
        issue(1'b1, 8'h11, 16'h1111, 1'b0, 1'b1, a1);
        issue(1'b1, 8'h12, 16'h2222, 1'b0, 1'b0, a2);
        chk("b2b_spacing", a2 - a1, 1 + WR + GP);
        issue(1'b0, 8'h11, 16'h0000, 1'b0, 1'b1, a1);
        issue(1'b0, 8'h12, 16'h0000, 1'b0, 1'b0, a2);
        chk("b2b_rd_spacing", a2 - a1, 1 + RD + GP);
        drain();

        // Address extremes
        issue(1'b1, 8'hFF, 16'h1234, 1'b0, 1'b0, a1);
        issue(1'b1, 8'h00, 16'h5678, 1'b0, 1'b0, a1);
        issue(1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, a1);
        issue(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, a1);
        drain();

`ifdef MEM_CTRL_AUTOINC_EN
        // Pointer wrap FF -> 00
        issue(1'b1, 8'hFF, 16'hBEEF, 1'b0, 1'b0, a1);
        issue(1'b1, 8'h55, 16'hC0DE, 1'b1, 1'b0, a1);
        issue(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, a1);
        issue(1'b0, 8'h77, 16'h0000, 1'b1, 1'b0, a1);
        drain();
`endif

        // Randomized traffic over a small address set at both ends
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(248, 255));
            issue(1'($urandom_range(0, 1)), ra, 16'($urandom), AUTOINC && ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), a1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req_valid = 1'b0;
        drain();

        // Reset five cycles into a write
        issue(1'b1, 8'h20, 16'hDEAD, 1'b0, 1'b0, a1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_mem_sel", mem_sel, 0);
        chk("abort_mem_we", mem_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_mem_wdata", mem_wdata, 0);
        chk("abort_rsp_rdata", rsp_rdata, 0);
        exp_acc.delete(); exp_rsp.delete();
        ref_def[8'h20] = 1'b0; ref_ptr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, a1);
        issue(1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, a1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
